piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_parity.sv | 14 +
 rtl/piso_tx.sv | 152 +++++++++++++++
 tb/tb_piso_tx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_tx serializer.
// The PARITY state is only reachable when PISO_TX_PARITY_EN is defined.
package piso_pkg;

  localparam int PISO_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_e;

endpackage

// File: rtl/piso_parity.sv
// Even-parity generator: XOR reduction of a WIDTH-bit word.
// Instantiated by piso_tx only when PISO_TX_PARITY_EN is defined.
module piso_parity
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_parity
);

  assign o_parity = ^i_data;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load handshake and
// fully registered outputs. Define PISO_TX_PARITY_EN to append an even-parity bit.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             d_out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  piso_state_e      r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_dout, w_dout_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_start, w_start_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_ready, w_ready_nxt;

  logic             w_accept;
  logic             w_last;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_load_shift;
  logic [WIDTH-1:0] w_run_shift;

`ifdef PISO_TX_PARITY_EN
  logic r_par, w_par_nxt, w_din_par;

  piso_parity #(.WIDTH(WIDTH)) u_parity (
    .i_data   (d_in),
    .o_parity (w_din_par)
  );
`endif

  // The bit to emit next always sits at the "front" end of r_shift.
  assign w_first_bit  = (MSB_FIRST != 0) ? d_in[WIDTH-1]    : d_in[0];
  assign w_next_bit   = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
  assign w_load_shift = (MSB_FIRST != 0) ? (d_in << 1)      : (d_in >> 1);
  assign w_run_shift  = (MSB_FIRST != 0) ? (r_shift << 1)   : (r_shift >> 1);

  assign w_accept  = load_valid && r_ready;
  assign w_last    = (r_state == SHIFT) && (r_cnt == LAST_IDX);
  assign w_cnt_inc = r_cnt + CW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_start_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_ready_nxt = 1'b0;
`ifdef PISO_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (w_accept) begin
      w_state_nxt = SHIFT;
      w_shift_nxt = w_load_shift;
      w_cnt_nxt   = '0;
      w_dout_nxt  = w_first_bit;
      w_valid_nxt = 1'b1;
      w_start_nxt = 1'b1;
      w_busy_nxt  = 1'b1;
`ifdef PISO_TX_PARITY_EN
      w_par_nxt   = w_din_par;
`endif
    end else begin
      case (r_state)
        SHIFT: begin
          if (w_last) begin
`ifdef PISO_TX_PARITY_EN
            w_state_nxt = PARITY;
            w_dout_nxt  = r_par;
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
            w_ready_nxt = 1'b1;
`else
            w_state_nxt = IDLE;
            w_ready_nxt = 1'b1;
`endif
          end else begin
            w_cnt_nxt   = w_cnt_inc;
            w_shift_nxt = w_run_shift;
            w_dout_nxt  = w_next_bit;
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
`ifdef PISO_TX_PARITY_EN
            w_ready_nxt = 1'b0;
`else
            // Ready is raised one cycle early so it is registered on the final bit.
            w_ready_nxt = (w_cnt_inc == LAST_IDX);
`endif
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_ready_nxt = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
`ifdef PISO_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
      r_start <= w_start_nxt;
      r_busy  <= w_busy_nxt;
      r_ready <= w_ready_nxt;
`ifdef PISO_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign load_ready  = r_ready;
  assign d_out       = r_dout;
  assign out_valid   = r_valid;
  assign frame_start = r_start;
  assign busy        = r_busy;

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx (WIDTH=4, both bit orders).
// Expectations switch on PISO_TX_PARITY_EN to cover the parity build as well.
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
  localparam int FRAME = 5;
  localparam logic [0:FRAME-1]   MSB_1011  = 5'b10111;
  localparam logic [0:FRAME-1]   LSB_1011  = 5'b11011;
  localparam logic [0:FRAME-1]   BITS_0110 = 5'b01100;
  localparam logic [0:2*FRAME-1] BITS_A5   = 10'b1010001010;
`else
  localparam int FRAME = 4;
  localparam logic [0:FRAME-1]   MSB_1011  = 4'b1011;
  localparam logic [0:FRAME-1]   LSB_1011  = 4'b1101;
  localparam logic [0:FRAME-1]   BITS_0110 = 4'b0110;
  localparam logic [0:2*FRAME-1] BITS_A5   = 8'b10100101;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] d_in;
  logic       load_valid;
  logic       readyMsb, dMsb, validMsb, startMsb, busyMsb;
  logic       readyLsb, dLsb, validLsb, startLsb, busyLsb;
  logic [3:0] sipoReg;
  int         sipoCnt;
  int         total;
  int         bad;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1)) dutMsb (
    .clk         (clk),
    .rst         (rst),
    .d_in        (d_in),
    .load_valid  (load_valid),
    .load_ready  (readyMsb),
    .d_out       (dMsb),
    .out_valid   (validMsb),
    .frame_start (startMsb),
    .busy        (busyMsb)
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(0)) dutLsb (
    .clk         (clk),
    .rst         (rst),
    .d_in        (d_in),
    .load_valid  (load_valid),
    .load_ready  (readyLsb),
    .d_out       (dLsb),
    .out_valid   (validLsb),
    .frame_start (startLsb),
    .busy        (busyLsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiving sipo: captures the data bits of each frame, MSB first, ignoring parity.
  always @(negedge clk) begin
    if (validMsb) begin
      if (startMsb) begin
        sipoReg <= {3'b000, dMsb};
        sipoCnt <= 1;
      end else if (sipoCnt < 4) begin
        sipoReg <= {sipoReg[2:0], dMsb};
        sipoCnt <= sipoCnt + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] word);
    @(posedge clk); #1;
    d_in       = word;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total      = 0;
    bad        = 0;
    sipoReg    = 4'h0;
    sipoCnt    = 0;
    rst        = 1'b0;
    d_in       = 4'h0;
    load_valid = 1'b0;

    @(negedge clk);
    checkOutput("rst_dout",  32'(dMsb),     32'd0);
    checkOutput("rst_valid", 32'(validMsb), 32'd0);
    checkOutput("rst_start", 32'(startMsb), 32'd0);
    checkOutput("rst_busy",  32'(busyMsb),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rel_ready", 32'(readyMsb), 32'd1);

    applyStimulus(4'b1011);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checkOutput($sformatf("msb_bit%0d", i),   32'(dMsb),     32'(MSB_1011[i]));
      checkOutput($sformatf("lsb_bit%0d", i),   32'(dLsb),     32'(LSB_1011[i]));
      checkOutput($sformatf("msb_valid%0d", i), 32'(validMsb), 32'd1);
      checkOutput($sformatf("lsb_valid%0d", i), 32'(validLsb), 32'd1);
      checkOutput($sformatf("msb_start%0d", i), 32'(startMsb), 32'(i == 0));
      checkOutput($sformatf("msb_busy%0d", i),  32'(busyMsb),  32'd1);
      checkOutput($sformatf("msb_ready%0d", i), 32'(readyMsb), 32'(i == FRAME - 1));
    end
    @(negedge clk);
    checkOutput("end_valid", 32'(validMsb), 32'd0);
    checkOutput("end_busy",  32'(busyMsb),  32'd0);
    checkOutput("end_dout",  32'(dMsb),     32'd0);
    checkOutput("end_ready", 32'(readyMsb), 32'd1);
    checkOutput("lsb_end",   32'(validLsb), 32'd0);

    @(posedge clk); #1;
    d_in       = 4'hA;
    load_valid = 1'b1;
    @(posedge clk); #1;
    d_in = 4'h5;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b_bit%0d", i),   32'(dMsb),     32'(BITS_A5[i]));
      checkOutput($sformatf("b2b_valid%0d", i), 32'(validMsb), 32'd1);
      checkOutput($sformatf("b2b_busy%0d", i),  32'(busyMsb),  32'd1);
      checkOutput($sformatf("b2b_start%0d", i), 32'(startMsb), 32'((i == 0) || (i == FRAME)));
      if (i == FRAME - 1) begin
        @(posedge clk); #1;
        load_valid = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("b2b_idle_valid", 32'(validMsb), 32'd0);
    checkOutput("b2b_idle_busy",  32'(busyMsb),  32'd0);

    applyStimulus(4'b0110);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checkOutput($sformatf("loop_bit%0d", i), 32'(dMsb), 32'(BITS_0110[i]));
    end
    @(negedge clk);
    checkOutput("loop_sipo", 32'(sipoReg), 32'h6);

    applyStimulus(4'b1011);
    @(negedge clk);
    checkOutput("ign_bit0", 32'(dMsb), 32'd1);
    d_in       = 4'h0;
    load_valid = 1'b1;
    @(negedge clk);
    checkOutput("ign_bit1", 32'(dMsb), 32'd0);
    load_valid = 1'b0;
    for (int i = 2; i < FRAME; i++) begin
      @(negedge clk);
      checkOutput($sformatf("ign_bit%0d", i),   32'(dMsb),     32'(MSB_1011[i]));
      checkOutput($sformatf("ign_start%0d", i), 32'(startMsb), 32'd0);
    end
    @(negedge clk);
    checkOutput("ign_idle_valid", 32'(validMsb), 32'd0);

    applyStimulus(4'hF);
    @(negedge clk);
    checkOutput("mid_bit0", 32'(dMsb), 32'd1);
    @(negedge clk);
    checkOutput("mid_bit1", 32'(dMsb), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_dout",  32'(dMsb),     32'd0);
    checkOutput("mid_rst_valid", 32'(validMsb), 32'd0);
    checkOutput("mid_rst_busy",  32'(busyMsb),  32'd0);
    checkOutput("mid_rst_start", 32'(startMsb), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_rel_ready", 32'(readyMsb), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mid_post_valid%0d", i), 32'(validMsb), 32'd0);
      checkOutput($sformatf("mid_post_dout%0d", i),  32'(dMsb),     32'd0);
      checkOutput($sformatf("mid_post_ready%0d", i), 32'(readyMsb), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
